sp_sram_pipe: RTL
=================

Name: sp_sram_pipe

Overview:
Parametrised successor to the single-port SRAM model used for I-memory and D-memory in the core testbench. It adds configurable data width, depth and read latency, a valid/ready request channel, and a valid/ready response channel with a small response FIFO. It sits between RISCV_TOP memory ports and the bench, so the core can be exercised against multi-cycle memories.

Parameters:
DWIDTH, 32, data word width in bits; multiple of 8, 8..128
AWIDTH, 10, word-address width
SIZE, 1024, number of words; at most 2**AWIDTH
LATENCY, 1, read latency in cycles from request accept to response entering the FIFO; 1..4
ROMDATA, "", $readmemh init file; empty string means no init, contents X

Ports:
CLK  in  1  clock, all state on rising edge
RST  in  1  asynchronous active-high reset
REQ_VALID  in  1  request present
REQ_READY  out  1  request accepted when VALID&&READY
REQ_WEN  in  1  0 = write, 1 = read (core polarity)
REQ_ADDR  in  AWIDTH  word address
REQ_BE  in  DWIDTH/8  byte enables, 1 = byte written
REQ_DI  in  DWIDTH  write data
RSP_VALID  out  1  read data available
RSP_READY  in  1  consumer takes response when VALID&&READY
RSP_DOUT  out  DWIDTH  read data
RSP_ERR  out  1  address-error flag for RSP_DOUT (optional feature)

Behaviour:
- Reset (async assert, sync release): pipeline valid bits 0, FIFO empty, credit counter 0, RSP_VALID=0, RSP_DOUT=0, RSP_ERR=0, REQ_READY=1 after release. Array contents not reset; ROMDATA loaded once at time 0 only.
- Reset mid-operation discards all in-flight and queued reads. No response is ever produced for them.
- Write: accepted write updates the enabled bytes at the accept edge. No response. A write with BE all-zero is accepted with no effect.
- Read: the array is sampled at the accept edge. Data shifts through LATENCY-1 further register stages and enters the FIFO at edge accept+LATENCY. RSP_VALID rises in the cycle after that edge when the FIFO was empty. Minimum observed latency is LATENCY cycles.
- Read-after-write: a read accepted any cycle after a write to the same address returns the new data.
- Response FIFO: depth LATENCY+1. RSP_DOUT/RSP_ERR show the FIFO head and are stable while RSP_VALID&&!RSP_READY.
- Credits: counter = reads in pipeline + entries in FIFO, range 0..LATENCY+1. Increment on read accept; decrement on response pop. Both in the same cycle leave it unchanged.
- REQ_READY = (credits < LATENCY+1) || (RSP_VALID && RSP_READY). This is combinational from RSP_READY, so the FIFO never overflows. Writes are blocked by the same condition so ordering is preserved.
- Full throughput: with RSP_READY held at 1, one read per cycle is sustained indefinitely.
- Back-pressure: with RSP_READY=0, exactly LATENCY+1 reads are accepted, then REQ_READY=0.
- Address >= SIZE: writes are ignored. Reads return 0.

Optional Feature:
SRAM_BOUNDS_CHECK_EN. When defined, any read with REQ_ADDR >= SIZE returns RSP_ERR=1 alongside RSP_DOUT=0. An out-of-range write issues $display with the address and sets a sticky internal flag, err_seen, visible hierarchically; err_seen is cleared by RST. When not defined, RSP_ERR is tied 0 and no checking logic or messages exist.

Decomposition:
- Package sram_pkg:
  - constant LAT_MAX=4
  - function be_width(dwidth) returning dwidth/8
  - function clog2 for FIFO and credit widths
- One sub-module, sram_rsp_fifo: parametrised by width (DWIDTH+1) and depth. It has push/pop/full/empty ports and the same CLK/RST.

Test Plan:
- Latency: LATENCY=3; write 0xDEADBEEF to addr 5, BE=4'hF; read addr 5 next cycle → RSP_VALID rises 3 cycles after the read accept edge with RSP_DOUT=0xDEADBEEF.
- Byte enables: addr 7 holds 0x11223344; write 0xAABBCCDD with BE=4'b0101; read addr 7 → 0x11BB33DD.
- Back-pressure: LATENCY=2, RSP_READY=0, REQ_VALID read held high → exactly 3 accepts, then REQ_READY=0. Raise RSP_READY → 3 responses in order, REQ_READY=1 again.
- Throughput: LATENCY=1, RSP_READY=1, reads of addrs 0..15 back-to-back → 16 consecutive RSP_VALID cycles, data in address order, no bubbles.
- Reset mid-flight: LATENCY=4, 3 reads in flight, assert RST for 1 cycle → RSP_VALID=0 immediately and stays 0, REQ_READY=1 after release, array data retained.
- Bounds (macro defined): SIZE=1024, read addr 1024 → RSP_ERR=1, RSP_DOUT=0. With the macro undefined, the same read → RSP_ERR=0, RSP_DOUT=0.

Source files
------------

// File: rtl/sp_sram_pipe_pkg.sv
// sram_pkg: shared constants, request opcode encoding and sizing helpers
// for the pipelined single-port SRAM (sp_sram_pipe) and its response FIFO.
package sram_pkg;

  // Largest supported read latency; also bounds the response FIFO depth.
  localparam int unsigned LAT_MAX = 4;

  // Request opcode as driven by the core: REQ_WEN low means write.
  typedef enum logic {
    OP_WRITE = 1'b0,
    OP_READ  = 1'b1
  } req_op_e;

  // Number of byte lanes in a data word.
  function automatic int unsigned be_width(input int unsigned dwidth);
    return dwidth / 8;
  endfunction

  // Ceiling log2 with a floor of 1 bit, for pointer and counter widths.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 1;
    for (int unsigned i = 1; i < 31; i++) begin
      if ((32'd1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// sram_rsp_fifo: small synchronous FIFO holding read responses until the
// consumer takes them. Depth need not be a power of two; pointers wrap
// explicitly. Storage is cleared on reset so the head reads as zero.
module sram_rsp_fifo
  import sram_pkg::*;
#(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = clog2(DEPTH);
  localparam int unsigned CW = clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign dout    = store[rd_ptr];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Storage, pointers and occupancy; push and pop may happen together.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned i = 0; i < DEPTH; i++) store[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        store[wr_ptr] <= din;
        wr_ptr        <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      end
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/sp_sram_pipe.sv
// sp_sram_pipe: parametrised single-port SRAM with a valid/ready request
// channel, fixed read latency and a valid/ready response channel backed by
// a credit-guarded response FIFO of depth LATENCY+1.
// Optional feature macro: SRAM_BOUNDS_CHECK_EN (flags out-of-range access).
module sp_sram_pipe
  import sram_pkg::*;
#(
  parameter int unsigned DWIDTH  = 32,
  parameter int unsigned AWIDTH  = 10,
  parameter int unsigned SIZE    = 1024,
  parameter int unsigned LATENCY = 1,
  parameter string       ROMDATA = ""
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        REQ_VALID,
  output logic                        REQ_READY,
  input  logic                        REQ_WEN,
  input  logic [AWIDTH-1:0]           REQ_ADDR,
  input  logic [be_width(DWIDTH)-1:0] REQ_BE,
  input  logic [DWIDTH-1:0]           REQ_DI,
  output logic                        RSP_VALID,
  input  logic                        RSP_READY,
  output logic [DWIDTH-1:0]           RSP_DOUT,
  output logic                        RSP_ERR
);

  localparam int unsigned BEW   = be_width(DWIDTH);
  localparam int unsigned DEPTH = LATENCY + 1;
  localparam int unsigned CW    = clog2(DEPTH + 1);
  localparam int unsigned IW    = clog2(SIZE);
  localparam logic [CW-1:0]     CREDIT_MAX = CW'(DEPTH);
  localparam logic [AWIDTH:0]   SIZE_LIM   = (AWIDTH + 1)'(SIZE);

  logic [DWIDTH-1:0] mem [SIZE];

  req_op_e           op;
  logic              acc;
  logic              rd_acc;
  logic              wr_acc;
  logic              in_range;
  logic              rd_err;
  logic              pop;
  logic [IW-1:0]     idx;
  logic [DWIDTH-1:0] rd_word;

  logic [LATENCY-1:0] pipe_vld;
  logic [DWIDTH:0]    pipe_data [LATENCY];

  logic [CW-1:0]   credits;
  logic            fifo_full;
  logic            fifo_empty;
  logic [DWIDTH:0] fifo_dout;

  assign op       = req_op_e'(REQ_WEN);
  assign in_range = ({1'b0, REQ_ADDR} < SIZE_LIM);
  assign idx      = REQ_ADDR[IW-1:0];

  assign RSP_VALID = !fifo_empty;
  assign pop       = RSP_VALID && RSP_READY;
  // A same-cycle pop frees a slot, so a full credit count can still accept.
  assign REQ_READY = (credits < CREDIT_MAX) || pop;
  assign acc       = REQ_VALID && REQ_READY;
  assign rd_acc    = acc && (op == OP_READ);
  assign wr_acc    = acc && (op == OP_WRITE) && in_range;

`ifdef SRAM_BOUNDS_CHECK_EN
  assign rd_err = !in_range;
`else
  assign rd_err = 1'b0;
`endif

  // Array read port: out-of-range reads yield zero.
  always_comb begin
    rd_word = '0;
    if (in_range) rd_word = mem[idx];
  end

  // Byte-enabled array write at the accept edge; contents are never reset.
  always_ff @(posedge CLK) begin
    if (wr_acc) begin
      for (int unsigned b = 0; b < BEW; b++) begin
        if (REQ_BE[b]) mem[idx][b*8 +: 8] <= REQ_DI[b*8 +: 8];
      end
    end
  end

  // Read pipeline: sample at accept, then LATENCY-1 further register stages.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pipe_vld <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) pipe_data[i] <= '0;
    end else begin
      pipe_vld[0] <= rd_acc;
      if (rd_acc) pipe_data[0] <= {rd_err, rd_word};
      for (int unsigned i = 1; i < LATENCY; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_data[i] <= pipe_data[i-1];
      end
    end
  end

  // Credits count reads in the pipeline plus entries waiting in the FIFO.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) credits <= '0;
    else     credits <= credits + CW'(rd_acc) - CW'(pop);
  end

  sram_rsp_fifo #(
    .WIDTH (DWIDTH + 1),
    .DEPTH (DEPTH)
  ) u_rsp_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (pipe_vld[LATENCY-1]),
    .din   (pipe_data[LATENCY-1]),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign RSP_DOUT = fifo_dout[DWIDTH-1:0];

  // Credit accounting already prevents overflow, so full is informational.
  logic unused_full;
  assign unused_full = fifo_full;

`ifdef SRAM_BOUNDS_CHECK_EN
  assign RSP_ERR = fifo_dout[DWIDTH];

  logic err_seen;

  // Sticky record of any out-of-range write, with a message per occurrence.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      err_seen <= 1'b0;
    end else if (acc && (op == OP_WRITE) && !in_range) begin
      err_seen <= 1'b1;
      $display("sp_sram_pipe: out-of-range write to address 0x%0h", REQ_ADDR);
    end
  end
`else
  assign RSP_ERR = 1'b0;

  logic unused_err;
  assign unused_err = fifo_dout[DWIDTH];
`endif

endmodule
